// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass
// and a per-register busy scoreboard for pending writes.
module regfile_mp #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_REGS      = 32,
   parameter int NUM_RD_PORTS  = 2,
   parameter int NUM_WR_PORTS  = 2,
   parameter bit BYPASS_EN     = 1'b1,
   parameter bit ZERO_REG_EN   = 1'b1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_WR_PORTS-1:0]               rg_wrt_en,
   input  logic [NUM_WR_PORTS*ADDRESS_WIDTH-1:0] rg_wrt_dest,
   input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0]    rg_wrt_data,
   input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rg_rd_addr,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rg_rd_data,
   output logic [NUM_RD_PORTS-1:0]               rg_rd_busy,
   input  logic                                  rsv_en,
   input  logic [ADDRESS_WIDTH-1:0]              rsv_dest,
   output logic                                  wr_conflict
);

   localparam int AW = ADDRESS_WIDTH;
   localparam int DW = DATA_WIDTH;

   logic [DW-1:0]           r_regs [NUM_REGS];
   logic [NUM_REGS-1:0]     r_busy;
   logic                    r_conflict;

   logic [AW-1:0]           w_wdest [NUM_WR_PORTS];
   logic [DW-1:0]           w_wdata [NUM_WR_PORTS];
   logic [NUM_WR_PORTS-1:0] w_wvalid;
   logic                    w_collide;

   // Register that may actually hold state (in range, not hardwired x0).
   function automatic logic f_live(input logic [AW-1:0] a);
      f_live = (int'(a) < NUM_REGS) && !(ZERO_REG_EN && (a == '0));
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
         w_wdest[k]  = rg_wrt_dest[k*AW +: AW];
         w_wdata[k]  = rg_wrt_data[k*DW +: DW];
         w_wvalid[k] = rg_wrt_en[k] && f_live(rg_wrt_dest[k*AW +: AW]);
      end
   end

   // Raw destination compare: x0 collisions also count.
   always_comb begin
      w_collide = 1'b0;
      for (int i = 0; i < NUM_WR_PORTS; i++) begin
         for (int j = i + 1; j < NUM_WR_PORTS; j++) begin
            if (rg_wrt_en[i] && rg_wrt_en[j] &&
                (rg_wrt_dest[i*AW +: AW] == rg_wrt_dest[j*AW +: AW]))
               w_collide = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGS; r++)
            r_regs[r] <= '0;
         r_busy     <= '0;
         r_conflict <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (w_wvalid[k]) begin
               r_regs[w_wdest[k]] <= w_wdata[k];
               r_busy[w_wdest[k]] <= 1'b0;
            end
         end
         if (rsv_en && f_live(rsv_dest))
            r_busy[rsv_dest] <= 1'b1;
         r_conflict <= w_collide;
      end
   end

   always_comb begin
      rg_rd_data = '0;
      rg_rd_busy = '0;
      for (int j = 0; j < NUM_RD_PORTS; j++) begin
         if (f_live(rg_rd_addr[j*AW +: AW])) begin
            rg_rd_data[j*DW +: DW] = r_regs[rg_rd_addr[j*AW +: AW]];
            rg_rd_busy[j]          = r_busy[rg_rd_addr[j*AW +: AW]];
         end
         if (BYPASS_EN) begin
            for (int k = 0; k < NUM_WR_PORTS; k++) begin
               if (w_wvalid[k] && (w_wdest[k] == rg_rd_addr[j*AW +: AW])) begin
                  rg_rd_data[j*DW +: DW] = w_wdata[k];
                  rg_rd_busy[j]          = 1'b0;
               end
            end
         end
      end
   end

   assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an
// architectural model of the register file and scoreboard.
module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  en;
   logic [9:0]  dest;
   logic [63:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rbusy;
   logic        rsv_en;
   logic [4:0]  rsv_dest;
   logic        wr_conflict;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_regs [32];
   bit          m_busy [32];
   bit          m_conf;

   always #5 clk = ~clk;

   regfile_mp dut (
      .clk         (clk),
      .rst         (rst),
      .rg_wrt_en   (en),
      .rg_wrt_dest (dest),
      .rg_wrt_data (wdata),
      .rg_rd_addr  (raddr),
      .rg_rd_data  (rdata),
      .rg_rd_busy  (rbusy),
      .rsv_en      (rsv_en),
      .rsv_dest    (rsv_dest),
      .wr_conflict (wr_conflict)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Latest writer in port order wins; x0 reads as zero.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      logic [31:0] v;
      if (a == 5'd0) return 32'd0;
      v = m_regs[a];
      if (en[0] && dest[4:0] == a) v = wdata[31:0];
      if (en[1] && dest[9:5] == a) v = wdata[63:32];
      return v;
   endfunction

   function automatic bit exp_busy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if ((en[0] && dest[4:0] == a) || (en[1] && dest[9:5] == a))
         return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_edge();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
         end
         m_conf = 1'b0;
      end else begin
         m_conf = en[0] && en[1] && (dest[4:0] == dest[9:5]);
         for (int k = 0; k < 2; k++) begin
            if (en[k] && dest[k*5 +: 5] != 5'd0) begin
               m_regs[dest[k*5 +: 5]] = wdata[k*32 +: 32];
               m_busy[dest[k*5 +: 5]] = 1'b0;
            end
         end
         if (rsv_en && rsv_dest != 5'd0) m_busy[rsv_dest] = 1'b1;
      end
   endtask

   task automatic drive(input logic [1:0] e, input logic [4:0] d0,
                        input logic [31:0] v0, input logic [4:0] d1,
                        input logic [31:0] v1, input logic rv,
                        input logic [4:0] rd, input logic r,
                        input logic [4:0] a0, input logic [4:0] a1);
      en       = e;
      dest     = {d1, d0};
      wdata    = {v1, v0};
      rsv_en   = rv;
      rsv_dest = rd;
      rst      = r;
      raddr    = {a1, a0};
   endtask

   task automatic step(input string tag);
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         check({tag, "_rd"}, rdata[j*32 +: 32], exp_rd(raddr[j*5 +: 5]));
         check({tag, "_bz"}, 32'(rbusy[j]), 32'(exp_busy(raddr[j*5 +: 5])));
      end
      check({tag, "_cf"}, 32'(wr_conflict), 32'(m_conf));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, a0, a1);
   endtask

   initial begin
      drive(2'b11, 5'd9, 32'h1111, 5'd9, 32'h2222, 1'b1, 5'd9, 1'b1,
            5'd0, 5'd0);
      repeat (2) @(posedge clk);
      model_edge();
      #1;

      for (int i = 0; i < 16; i++) begin
         idle(5'(2*i), 5'(2*i+1));
         #2;
         check("rst_d0", rdata[31:0], 32'd0);
         check("rst_d1", rdata[63:32], 32'd0);
         check("rst_bz", 32'(rbusy), 32'd0);
         check("rst_cf", 32'(wr_conflict), 32'd0);
         step("rst");
      end

      drive(2'b11, 5'd5, 32'hDEADBEEF, 5'd6, 32'h12345678, 1'b0, 5'd0,
            1'b0, 5'd5, 5'd6);
      #2;
      check("byp_x5", rdata[31:0], 32'hDEADBEEF);
      check("byp_x6", rdata[63:32], 32'h12345678);
      step("wr56");
      idle(5'd5, 5'd6);
      #2;
      check("rd_x5", rdata[31:0], 32'hDEADBEEF);
      check("rd_x6", rdata[63:32], 32'h12345678);
      step("rd56");

      drive(2'b11, 5'd7, 32'h1, 5'd7, 32'h2, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
      #2;
      check("col_byp", rdata[31:0], 32'h2);
      step("col");
      idle(5'd7, 5'd0);
      #2;
      check("col_x7", rdata[31:0], 32'h2);
      check("col_cf1", 32'(wr_conflict), 32'd1);
      step("col1");
      idle(5'd7, 5'd0);
      #2;
      check("col_cf0", 32'(wr_conflict), 32'd0);
      step("col2");

      drive(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
            5'd0, 5'd0);
      #2;
      check("x0_byp", rdata[31:0], 32'd0);
      step("x0w");
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
      step("x0r");
      idle(5'd0, 5'd0);
      #2;
      check("x0_val", rdata[31:0], 32'd0);
      check("x0_bz", 32'(rbusy[0]), 32'd0);
      step("x0c");

      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0,
            5'd10, 5'd10);
      step("sb_r");
      drive(2'b01, 5'd10, 32'hAB, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0,
            5'd10, 5'd10);
      #2;
      check("sb_bz1", 32'(rbusy[0]), 32'd0);
      step("sb_wr");
      idle(5'd10, 5'd10);
      #2;
      check("sb_bz2", 32'(rbusy[0]), 32'd1);
      check("sb_ab", rdata[31:0], 32'hAB);
      step("sb_h");
      drive(2'b01, 5'd10, 32'hCD, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0,
            5'd10, 5'd10);
      step("sb_w2");
      idle(5'd10, 5'd10);
      #2;
      check("sb_bz0", 32'(rbusy[0]), 32'd0);
      check("sb_cd", rdata[31:0], 32'hCD);
      step("sb_c");

      drive(2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd3, 5'd4);
      step("mrst");
      idle(5'd3, 5'd4);
      #2;
      check("mrst_x3", rdata[31:0], 32'd0);
      check("mrst_b4", 32'(rbusy[1]), 32'd0);
      step("mrst2");

      for (int n = 0; n < 400; n++) begin
         drive(2'($urandom), 5'($urandom_range(0, 11)), $urandom,
               5'($urandom_range(0, 11)), $urandom, 1'($urandom),
               5'($urandom_range(0, 11)), ($urandom_range(0, 49) == 0),
               5'($urandom_range(0, 11)), 5'($urandom_range(0, 31)));
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the RISC-V datapath. Successor to the 2-read/1-write file.
- Configurable numbers of read and write ports, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for pending writes.
- Used by the decode stage for operand reads and hazard checks; writeback drives the write ports.

Parameters:
- DATA_WIDTH, 32, bits per register
- ADDRESS_WIDTH, 5, register index width
- NUM_REGS, 32, number of registers (≤ 2^ADDRESS_WIDTH)
- NUM_RD_PORTS, 2, number of read ports (≥1)
- NUM_WR_PORTS, 2, number of write ports (≥1)
- BYPASS_EN, 1, 1 = same-cycle write data is visible on reads
- ZERO_REG_EN, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rg_wrt_en  in  NUM_WR_PORTS  per-port write enable
- rg_wrt_dest  in  NUM_WR_PORTS*ADDRESS_WIDTH  per-port destination; port k occupies slice [k*AW +: AW]
- rg_wrt_data  in  NUM_WR_PORTS*DATA_WIDTH  per-port write data
- rg_rd_addr  in  NUM_RD_PORTS*ADDRESS_WIDTH  per-port read address
- rg_rd_data  out  NUM_RD_PORTS*DATA_WIDTH  per-port read data (combinational)
- rg_rd_busy  out  NUM_RD_PORTS  1 = read register has a pending reserved write
- rsv_en  in  1  reserve request: mark rsv_dest busy
- rsv_dest  in  ADDRESS_WIDTH  register to reserve
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same register last cycle

Behaviour:
- Clock and reset
  - One clock, clk. Reset rst is synchronous and active-high.
  - While rst=1 at a rising edge: all registers ← 0, all busy bits ← 0, wr_conflict ← 0. Writes and reservations in that cycle are ignored.
- Write
  - At a rising edge with rst=0, each port k with rg_wrt_en[k]=1 writes rg_wrt_data[k] to rg_wrt_dest[k].
  - If ZERO_REG_EN=1, writes to register 0 are dropped.
  - Writes to indices ≥ NUM_REGS are dropped.
- Write collision
  - If several enabled ports target the same register, the highest-index port wins.
  - wr_conflict=1 in the following cycle. Register 0 collisions also set the flag.
  - wr_conflict holds for exactly one cycle per colliding cycle.
- Read (zero latency)
  - rg_rd_data[j] = array[rg_rd_addr[j]].
  - If ZERO_REG_EN=1 and the address is 0, the output is 0.
  - An out-of-range address returns 0.
- Bypass
  - When BYPASS_EN=1 and an enabled write port targets rg_rd_addr[j] in the same cycle (non-zero when ZERO_REG_EN=1), rg_rd_data[j] shows that port's write data. The highest-index matching port wins.
  - When BYPASS_EN=0, reads return the old value until after the edge.
- Scoreboard
  - At a rising edge with rst=0: an enabled write to register r clears busy[r]; rsv_en=1 then sets busy[rsv_dest].
  - If both target the same register, set wins: the new producer is pending.
  - Reservation of register 0 is ignored when ZERO_REG_EN=1.
  - rg_rd_busy[j] = busy[rg_rd_addr[j]].
  - When BYPASS_EN=1, rg_rd_busy[j] is forced to 0 if an enabled write to that address occurs this cycle, because the data is forwarded.
- Reset mid-operation: rst overrides pending writes and reservations in the same edge. There is no partial state.
- No other state exists; there are no handshakes beyond the enables.

Test Plan:
- Reset, then read all 32 regs on both ports → every rg_rd_data = 0, rg_rd_busy = 0, wr_conflict = 0.
- Port0 writes x5 = 0xDEADBEEF and port1 writes x6 = 0x12345678 in the same cycle. Next cycle read x5, x6 → 0xDEADBEEF, 0x12345678. With BYPASS_EN=1 the same values appear in the write cycle.
- Port0 writes x7 = 0x1 and port1 writes x7 = 0x2 in the same cycle → x7 = 0x2 afterwards, wr_conflict = 1 for exactly one cycle.
- Write x0 = 0xFFFFFFFF, then read x0 → 0. Assert rsv_en for x0 → rg_rd_busy stays 0.
- Scoreboard sequence:
  - Reserve x10 → rg_rd_busy for x10 = 1 next cycle.
  - Write x10 = 0xAB while reserving x10 again → busy remains 1, data = 0xAB.
  - Write x10 = 0xCD with no reservation → busy = 0.
- Write x3 = 0x55 and reserve x4, asserting rst in the same cycle → next cycle x3 = 0, busy[x4] = 0.
